// File: rtl/ram_cmd_arbiter.sv
// rtl/ram_cmd_arbiter.sv - round-robin two-requester front end for the command-driven RAM
// Expands whole read/write transactions into {opcode, payload} RAM commands and returns responses.
module ram_cmd_arbiter #(
  parameter int TIMEOUT   = 4,
  parameter int ADDR_SIZE = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  input  logic [1:0]               req_we,
  input  logic [2*ADDR_SIZE-1:0]   req_addr,
  input  logic [2*ADDR_SIZE-1:0]   req_wdata,
  output logic [1:0]               req_ready,
  output logic [1:0]               rsp_valid,
  output logic [1:0]               rsp_err,
  output logic [ADDR_SIZE-1:0]     rsp_rdata,
  output logic [ADDR_SIZE+1:0]     ram_din,
  output logic                     ram_rx_valid,
  input  logic [ADDR_SIZE-1:0]     ram_dout,
  input  logic                     ram_tx_valid,
  output logic                     busy
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 win;

  // On a tie the requester that did not win last time is served.
  assign win = (&req_valid) ? ~last_q : req_valid[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      last_q  <= last_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    last_d       = last_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    rsp_err      = 2'b00;
    rsp_rdata    = '0;
    ram_din      = '0;
    ram_rx_valid = 1'b0;
    busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready[win] = 1'b1;
          gnt_d          = win;
          last_d         = win;
          we_d           = req_we[win];
          addr_d         = win ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
          wdata_d        = win ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata[ADDR_SIZE-1:0];
          rdata_d        = '0;
          err_d          = 1'b0;
          state_d        = req_we[win] ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        ram_din      = {2'b00, addr_q};
        ram_rx_valid = 1'b1;
        state_d      = WR_DATA;
      end
      WR_DATA: begin
        ram_din      = {2'b01, wdata_q};
        ram_rx_valid = 1'b1;
        state_d      = RESP;
      end
      RD_ADDR: begin
        ram_din      = {2'b10, addr_q};
        ram_rx_valid = 1'b1;
        state_d      = RD_CMD;
      end
      RD_CMD: begin
        ram_din      = {2'b11, {ADDR_SIZE{1'b0}}};
        ram_rx_valid = 1'b1;
        cnt_d        = '0;
        state_d      = RD_WAIT;
      end
      RD_WAIT: begin
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_err[gnt_q]   = err_q;
        rsp_rdata        = rdata_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
